pmod_input_conditioner: RTL and testbench
=========================================

Name: pmod_input_conditioner

Overview:
- Conditions one raw Pmod header input (mechanical switch/button or external logic) before it drives an LED or downstream logic.
- Synchronizes the pin to `clk`, debounces it with a counter-qualified FSM, and produces a clean level plus single-cycle rise/fall pulses.
- Sits directly upstream of any LED/indicator or control logic that today consumes the pin unconditioned.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive cycles the synced input must differ from `level` before `level` changes (10 ms at 100 MHz); legal range ≥2.
- SYNC_STAGES, 2: flip-flops in the synchronizer chain; legal range ≥2.
- STRETCH_CYCLES, 25000000: `led` high time after a rise, used only with the optional feature; legal range ≥1.

Ports:
- clk  input  1  system clock (100 MHz board clock)
- rst  input  1  reset, asynchronous, active-high
- pin  input  1  raw asynchronous Pmod input
- level  output  1  debounced, synchronized level
- rise  output  1  one-cycle pulse on debounced 0→1
- fall  output  1  one-cycle pulse on debounced 1→0
- led  output  1  indicator drive (see Optional Feature)

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high. All flops clear on `rst` assertion and release synchronously to `clk`.
- Reset values: `level`=0, `rise`=0, `fall`=0, `led`=0, sync chain all 0, counter 0, state STABLE_LO.
- Sync chain: SYNC_STAGES flops clocked by `clk`. `s` is the last stage. Nothing else samples `pin` directly.
- FSM states: STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO.
  - STABLE_LO: `s`=1 → CHECK_HI, counter←1. Otherwise hold, counter←0.
  - CHECK_HI: `s`=0 → STABLE_LO, counter←0 (glitch rejected). `s`=1 and counter==DEBOUNCE_CYCLES-1 → STABLE_HI. Otherwise counter++.
  - STABLE_HI and CHECK_LO mirror the above with polarity inverted.
- Counter width is $clog2(DEBOUNCE_CYCLES). The counter never wraps; it is cleared on every state change.
- `level` is registered and equals 1 exactly in STABLE_HI and CHECK_LO.
- `rise`/`fall`:
  - Registered; asserted for exactly one cycle, the first cycle the new `level` is visible.
  - Never both high.
  - Never high in consecutive cycles.
- Latency: a clean pin edge held indefinitely changes `level` on the (SYNC_STAGES + DEBOUNCE_CYCLES)th rising `clk` edge after the first edge that samples it.
- Glitch rule: a pulse on `s` lasting ≤ DEBOUNCE_CYCLES-1 cycles produces no change on any output.
- Bounce: the counter restarts from 1 at each re-entry to CHECK_*.
- Reset mid-check: the pending transition is discarded. If `pin` is high after release, it is treated as a fresh rise, so `rise` fires after the full latency.
- `pin` changing while `rst` is high: ignored.

Optional Feature:
- Macro: PMOD_INPUT_STRETCH_EN.
- Defined:
  - Adds a stretch down-counter, width $clog2(STRETCH_CYCLES+1).
  - `led` is high for exactly STRETCH_CYCLES cycles, starting the cycle `rise` is high.
  - A new `rise` during stretch reloads the counter (retrigger).
  - `fall` has no effect on `led`.
- Undefined: `led` = `level` (a wire copy, same cycle); no stretch logic is synthesized and STRETCH_CYCLES is unused.

Decomposition:
- Package `pmod_in_pkg`:
  - Enum typedef `deb_state_t` for the four FSM states.
  - Default constants CLK_HZ=100000000, DEBOUNCE_MS=10, and a derived DEBOUNCE_CYCLES_DEFAULT.
- Sub-module `sync_chain`:
  - Parameterized by SYNC_STAGES.
  - Async active-high reset to 0.
  - Reusable for other Pmod inputs.
- FSM, counter and stretch logic stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, STRETCH_CYCLES=3):
- Reset release with `pin`=0 → all outputs 0 and held for 20 cycles.
- `pin` 0→1 held → `level`=1 and `rise`=1 on the 6th rising edge after the change; `rise` returns to 0 the next cycle; `fall` stays 0.
- `pin` high for 3 cycles then low → `level`, `rise`, `fall` stay 0 throughout. Repeat with 4 cycles → `rise` fires once, then `fall` fires 4 cycles after `s` returns low.
- Bounce pattern 1,0,1,1,0,1,1,1,1 per cycle → exactly one `rise`, timed from the final 0→1 of `s`; no `fall`.
- `rst` pulsed during CHECK_HI with `pin` held 1 → outputs clear immediately (asynchronously); `rise` fires 6 edges after reset release.
- With PMOD_INPUT_STRETCH_EN: two rises 2 cycles apart → `led` high for 5 consecutive cycles. Without the macro: `led` tracks `level` exactly in every scenario above.

Source files
------------

// File: rtl/pmod_input_conditioner_pkg.sv
// rtl/pmod_input_conditioner_pkg.sv - shared states and timing defaults for the Pmod input conditioner
package pmod_in_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } deb_state_t;

  localparam int CLK_HZ                  = 100000000;
  localparam int DEBOUNCE_MS             = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/pmod_input_conditioner_sync_chain.sv
// rtl/pmod_input_conditioner_sync_chain.sv - multi-flop synchronizer for one asynchronous input
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pmod_input_conditioner.sv
// rtl/pmod_input_conditioner.sv - sync, debounce and edge-detect one Pmod input
// Optional LED pulse stretcher enabled by defining PMOD_INPUT_STRETCH_EN.
module pmod_input_conditioner
  import pmod_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = 2,
  parameter int STRETCH_CYCLES  = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall,
  output logic led
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2 || STRETCH_CYCLES < 1) begin : g_bad_cfg
    $error("pmod_input_conditioner: illegal parameter combination");
  end

  deb_state_t     r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_level;
  logic           r_rise;
  logic           r_fall;
  logic           w_s;
  logic           w_rise_next;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .i_d(pin),
    .o_q(w_s)
  );

  // The stretcher must load on the same edge that raises rise.
  assign w_rise_next = (r_state == CHECK_HI) && w_s && (r_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        STABLE_LO: begin
          if (w_s) begin
            r_state <= CHECK_HI;
            r_cnt   <= CNT_ONE;
          end else begin
            r_cnt <= '0;
          end
        end
        CHECK_HI: begin
          if (!w_s) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
          end else if (w_rise_next) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_rise  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!w_s) begin
            r_state <= CHECK_LO;
            r_cnt   <= CNT_ONE;
          end else begin
            r_cnt <= '0;
          end
        end
        CHECK_LO: begin
          if (w_s) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_fall  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= STABLE_LO;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

`ifdef PMOD_INPUT_STRETCH_EN
  localparam int            SW           = $clog2(STRETCH_CYCLES + 1);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYCLES);
  localparam logic [SW-1:0] STRETCH_ONE  = SW'(1);

  logic [SW-1:0] r_stretch;

  // A rise while still stretching reloads the full window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stretch <= '0;
    end else if (w_rise_next) begin
      r_stretch <= STRETCH_LOAD;
    end else if (r_stretch != '0) begin
      r_stretch <= r_stretch - STRETCH_ONE;
    end
  end

  assign led = (r_stretch != '0);
`else
  assign led = r_level;
`endif

endmodule

// File: tb/tb_pmod_input_conditioner.sv
// tb/tb_pmod_input_conditioner.sv - directed self-checking bench for pmod_input_conditioner
module tb_pmod_input_conditioner;

  localparam int DEB     = 4;
  localparam int SYNC    = 2;
  localparam int STRETCH = 3;

  logic clk;
  logic rst;
  logic pin;
  logic level;
  logic rise;
  logic fall;
  logic led;

  int n_checks;
  int n_errors;
  int st_left;

  pmod_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES(SYNC),
    .STRETCH_CYCLES(STRETCH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pin(pin),
    .level(level),
    .rise(rise),
    .fall(fall),
    .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_low(input string tag);
    check_eq($sformatf("%s.level", tag), level, 1'b0);
    check_eq($sformatf("%s.rise", tag), rise, 1'b0);
    check_eq($sformatf("%s.fall", tag), fall, 1'b0);
    check_eq($sformatf("%s.led", tag), led, 1'b0);
  endtask

  // re/fe: edge index (1-based, counted from the call) where rise/fall is expected; 0 = never
  task automatic step_check(input string tag, input int n, input int re, input int fe, input logic lvl0);
    logic lvl;
    logic exp_led;
    lvl = lvl0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (k == re) lvl = 1'b1;
      if (k == fe) lvl = 1'b0;
`ifdef PMOD_INPUT_STRETCH_EN
      if (k == re) st_left = STRETCH;
      exp_led = (st_left > 0);
      if (st_left > 0) st_left--;
`else
      exp_led = lvl;
`endif
      check_eq($sformatf("%s.level@%0d", tag, k), level, lvl);
      check_eq($sformatf("%s.rise@%0d", tag, k), rise, (k == re));
      check_eq($sformatf("%s.fall@%0d", tag, k), fall, (k == fe));
      check_eq($sformatf("%s.led@%0d", tag, k), led, exp_led);
    end
  endtask

  // Asserts rst mid-cycle, toggles pin while held, then releases with pin high.
  task automatic pulse_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    st_left = 0;
    check_all_low($sformatf("%s.async", tag));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      pin = ~pin;
      check_all_low($sformatf("%s.hold%0d", tag, i));
    end
    pin = 1'b1;
    rst = 1'b0;
  endtask

  logic [8:0] bounce_pat;

  initial begin
    n_checks = 0;
    n_errors = 0;
    st_left  = 0;
    rst = 1'b1;
    pin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_low("reset");
    rst = 1'b0;

    step_check("idle", 20, 0, 0, 1'b0);

    pin = 1'b1;
    step_check("rise", 10, 6, 0, 1'b0);
    pin = 1'b0;
    step_check("fall", 10, 0, 6, 1'b1);

    pin = 1'b1;
    step_check("glitch3_hi", 3, 0, 0, 1'b0);
    pin = 1'b0;
    step_check("glitch3_lo", 10, 0, 0, 1'b0);

    pin = 1'b1;
    step_check("pulse4_hi", 4, 0, 0, 1'b0);
    pin = 1'b0;
    step_check("pulse4_lo", 12, 2, 6, 1'b0);

    bounce_pat = 9'b1_1110_1101;
    for (int i = 0; i < 9; i++) begin
      pin = bounce_pat[i];
      step_check($sformatf("bounce%0d", i), 1, 0, 0, 1'b0);
    end
    step_check("bounce_rise", 8, 2, 0, 1'b0);
    pin = 1'b0;
    step_check("bounce_fall", 10, 0, 6, 1'b1);

    pin = 1'b1;
    step_check("pre_rst_hi", 10, 6, 0, 1'b0);
    pulse_reset("rst_hi");
    step_check("rst_hi_rise", 10, 6, 0, 1'b0);

    pin = 1'b0;
    step_check("lo_again", 10, 0, 6, 1'b1);
    pin = 1'b1;
    step_check("check_hi", 4, 0, 0, 1'b0);
    pulse_reset("rst_chk");
    step_check("rst_chk_rise", 10, 6, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
